pipe_scroller: RTL
==================

PIPE_SCROLLER -- requirements
Module: pipe_scroller

Interface
REQ-001 SHALL have parameter ROWS, default 16, meaning row count of LED field.
REQ-002 SHALL have parameter COLS, default 16, meaning column count of LED field.
REQ-003 SHALL have parameter PIPE_W, default 2, meaning number of columns per pipe.
REQ-004 SHALL have parameter SPACING, default 4, meaning number of empty columns between pipes.
REQ-005 SHALL have parameter GAP_H, default 4, meaning height in rows of the fly-through gap.
REQ-006 SHALL have parameter BIRD_COL, default 3, meaning bird column index used for scoring.
REQ-007 SHALL have port clk, input, 1, meaning the single system clock.
REQ-008 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-009 SHALL have port pattern, input, 3, meaning pseudo-random gap selector from the upstream LFSR Q output.
REQ-010 SHALL have port tick, input, 1, meaning one-cycle scroll-rate enable.
REQ-011 SHALL have port start, input, 1, meaning one-cycle game-start request.
REQ-012 SHALL have port halt, input, 1, meaning level freeze request (game over).
REQ-013 SHALL have port field, output, COLS x ROWS, meaning pipe pixels; field[c][r]=1 is lit; column 0 is leftmost.
REQ-014 SHALL have port score_pulse, output, 1, meaning one-cycle pulse per pipe cleared.
REQ-015 SHALL have port running, output, 1, meaning FSM is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SPACE, PIPE, FROZEN.
REQ-017 IDLE: field held; start=1 -> SPACE, space counter loaded with SPACING; no shift in that cycle even if tick=1.
REQ-018 Scroll step, taken only on tick=1 in SPACE or PIPE with halt=0: field[c] <= field[c+1] for c<COLS-1; field[COLS-1] <= new column; field[0] contents discarded.
REQ-019 SPACE: new column is all zeros; counter decrements per step; on the step where counter==1, latch gap_base = pattern + 2 (4-bit, range 2..9), load pipe counter with PIPE_W, enter PIPE.
REQ-020 PIPE: new column has rows gap_base..gap_base+GAP_H-1 = 0 and all other rows = 1; gap_base constant for all PIPE_W columns of one pipe; counter decrements per step; on the step where counter==1, reload SPACING and enter SPACE.
REQ-021 pattern SHALL be sampled only at the SPACE->PIPE step; changes at other times have no effect.
REQ-022 halt=1 in SPACE or PIPE -> FROZEN next cycle with no shift that cycle, even if tick=1; FROZEN holds field and counters until reset; start ignored in FROZEN.
REQ-023 start while in SPACE, PIPE or FROZEN SHALL be ignored.
REQ-024 score_pulse SHALL be registered, asserted the cycle after a scroll step in which pre-shift field[BIRD_COL] is non-zero and pre-shift field[BIRD_COL+1] is all-zero; never asserted in IDLE or FROZEN.
REQ-025 running SHALL be 1 in SPACE, PIPE and FROZEN, 0 in IDLE.
REQ-026 Pipes SHALL tile indefinitely: steady-state period PIPE_W+SPACING steps with no gap or overlap between columns.

Reset
REQ-027 reset=0 SHALL asynchronously force state IDLE, field all zeros, score_pulse 0, running 0, counters 0, gap_base 0.
REQ-028 reset asserted mid-scroll SHALL discard all pipes; after release, the block waits for a fresh start.
REQ-029 Outputs SHALL reach reset values within the same cycle reset falls, independent of clk.

Verification
REQ-030 Reset -> start -> 4 ticks, pattern=3'b101: after tick 4, field[15] = 1s except rows 7..10; after tick 5, field[15:14] identical; after tick 6, field[15]=0.
REQ-031 Continuous ticks for 40 steps: pipes occur every 6 columns, each 2 columns wide, with gap_base equal to pattern sampled at each SPACE->PIPE step plus 2.
REQ-032 Track first pipe to BIRD_COL: score_pulse high for exactly 1 cycle, 1 cycle after the step moving its trailing column out of column 3; 1 pulse per pipe.
REQ-033 halt and tick asserted in the same cycle mid-PIPE -> no shift, running=1, field unchanged for 20 further ticks; start ignored.
REQ-034 start and tick asserted in the same cycle from IDLE -> field stays all zeros that cycle, running=1 the next cycle.
REQ-035 reset pulsed low between clk edges while 3 pipes are on screen -> field all zeros and running=0 immediately; ticks ignored until start.

Source files
------------

// File: rtl/pipe_scroller.sv
// Side-scrolling pipe field: pipes of PIPE_W columns separated by SPACING empty
// columns enter at the right edge on each tick, with a gap placed from the LFSR pattern.
module pipe_scroller #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int PIPE_W   = 2,
  parameter int SPACING  = 4,
  parameter int GAP_H    = 4,
  parameter int BIRD_COL = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 pattern,
  input  logic                       tick,
  input  logic                       start,
  input  logic                       halt,
  output logic [COLS-1:0][ROWS-1:0]  field,
  output logic                       score_pulse,
  output logic                       running
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SPACE  = 2'd1;
  localparam logic [1:0] PIPE   = 2'd2;
  localparam logic [1:0] FROZEN = 2'd3;

  localparam int CNT_MAX = (SPACING > PIPE_W) ? SPACING : PIPE_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       gap_base;

  logic             step;
  logic             last;
  logic [3:0]       next_base;
  logic [ROWS-1:0]  new_col;
  logic             cleared;

  // Solid column with GAP_H unlit rows starting at base.
  function automatic logic [ROWS-1:0] pipe_col(input logic [3:0] base);
    logic [ROWS-1:0] col;
    col = '0;
    for (int r = 0; r < ROWS; r++)
      col[r] = !((r >= int'(base)) && (r < int'(base) + GAP_H));
    return col;
  endfunction

  assign step      = (state == SPACE || state == PIPE) && tick && !halt;
  assign last      = (cnt == CNT_W'(1));
  assign next_base = {1'b0, pattern} + 4'd2;
  assign cleared   = (|field[BIRD_COL]) && !(|field[BIRD_COL+1]);
  assign running   = (state != IDLE);

  // The column entering on a step belongs to the state being entered: the
  // SPACE->PIPE step already emits the first pipe column, the PIPE->SPACE step
  // emits the first empty one, so each pipe is PIPE_W wide and each space SPACING.
  always_comb begin
    new_col = '0;
    if (state == SPACE && last)
      new_col = pipe_col(next_base);
    else if (state == PIPE && !last)
      new_col = pipe_col(gap_base);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      gap_base    <= '0;
      field       <= '0;
      score_pulse <= 1'b0;
    end else begin
      score_pulse <= step && cleared;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SPACE;
            cnt   <= CNT_W'(SPACING);
          end
        end
        SPACE, PIPE: begin
          if (halt) begin
            state <= FROZEN;
          end else if (tick) begin
            field <= {new_col, field[COLS-1:1]};
            if (!last) begin
              cnt <= cnt - CNT_W'(1);
            end else if (state == SPACE) begin
              state    <= PIPE;
              gap_base <= next_base;
              cnt      <= CNT_W'(PIPE_W);
            end else begin
              state <= SPACE;
              cnt   <= CNT_W'(SPACING);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
